seq_alu_muldiv: RTL and testbench

- Parametrised, registered successor to the integer ALU. Executes the same SPARC V8 arithmetic, logical and shift op3 codes in one cycle.
- Adds iterative UMUL, SMUL, UDIV and SDIV (with cc variants), an internal Y register, registered icc flags, and a start/busy/done handshake.
- Sits in the execute stage. Control holds the pipeline while busy is high.

---
 rtl/seq_alu_muldiv.sv | 198 +++++++++++++++++++
 tb/tb_seq_alu_muldiv.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_muldiv.sv
// Registered execute-stage ALU: single-cycle SPARC arithmetic/logic/shift ops plus
// iterative multiply/divide with a Y register, icc flags and a start/busy/done handshake.
module seq_alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             y_we,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] y_out,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             trap
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    state_t r_state, w_next;

    logic [WIDTH-1:0] r_res, r_y, r_hi, r_lo, r_opb;
    logic [SHW-1:0]   r_cnt;
    logic             r_n, r_z, r_v, r_c, r_done, r_trap;
    logic             r_cc, r_is_div, r_neg_q, r_neg_r, r_ovf;

    // Handshake: an op is taken on a rising edge with start=1 while busy=0; done
    // (with trap on divide-by-zero/illegal op) is high for exactly one cycle after.
    logic w_low, w_is_mul, w_is_div, w_is_alu, w_is_shift, w_cc, w_accept, w_div0;
    assign w_low      = ~op[5];
    assign w_is_mul   = w_low && (op[3:1] == 3'b101);
    assign w_is_div   = w_low && (op[3:1] == 3'b111);
    assign w_is_alu   = w_low && ((op[3:0] <= 4'd8) || (op[3:0] == 4'd12));
    assign w_is_shift = (op == 6'd37) || (op == 6'd38) || (op == 6'd39);
    assign w_cc       = w_low && op[4];
    assign w_accept   = start && (r_state == S_IDLE);
    assign w_div0     = w_is_div && (b == '0);

    logic             w_cy;
    logic [WIDTH:0]   w_sum, w_dif;
    assign w_cy  = op[3] & cin;
    assign w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cy};
    assign w_dif = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cy};

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_v, w_alu_c;
    always_comb begin
        w_alu_res = '0;
        w_alu_v   = 1'b0;
        w_alu_c   = 1'b0;
        if (w_is_shift) begin
            case (op[1:0])
                2'b01:   w_alu_res = a << b[SHW-1:0];
                2'b10:   w_alu_res = a >> b[SHW-1:0];
                default: w_alu_res = $unsigned($signed(a) >>> b[SHW-1:0]);
            endcase
        end else begin
            case (op[3:0])
                4'd0, 4'd8: begin
                    w_alu_res = w_sum[WIDTH-1:0];
                    w_alu_c   = w_sum[WIDTH];
                    w_alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
                end
                4'd4, 4'd12: begin
                    w_alu_res = w_dif[WIDTH-1:0];
                    w_alu_c   = w_dif[WIDTH];
                    w_alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
                end
                4'd1:    w_alu_res = a & b;
                4'd2:    w_alu_res = a | b;
                4'd3:    w_alu_res = a ^ b;
                4'd5:    w_alu_res = a & ~b;
                4'd6:    w_alu_res = a | ~b;
                4'd7:    w_alu_res = ~(a ^ b);
                default: w_alu_res = '0;
            endcase
        end
    end

    // Signed mul/div run on magnitudes; signs are re-applied in S_FIX.
    logic             w_a_neg, w_b_neg, w_ovf;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    assign w_a_neg = op[0] & a[WIDTH-1];
    assign w_b_neg = op[0] & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
    assign w_ovf   = w_is_div && op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    logic [WIDTH:0]     w_madd, w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_res, w_fix_y;
    assign w_madd    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_trial   = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_opb};
    assign w_prod    = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_fix_res = r_is_div ? (r_neg_q ? -r_lo : r_lo) : w_prod[WIDTH-1:0];
    assign w_fix_y   = r_is_div ? (r_neg_r ? -r_hi : r_hi) : w_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)                 w_next = S_MUL;
                else if (w_accept && w_is_div && !w_div0) w_next = S_DIV;
            end
            S_MUL, S_DIV: if (r_cnt == SHW'(WIDTH-1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res <= '0;  r_y <= '0;  r_hi <= '0;  r_lo <= '0;  r_opb <= '0;  r_cnt <= '0;
            r_n <= 1'b0;  r_z <= 1'b0;  r_v <= 1'b0;  r_c <= 1'b0;
            r_done <= 1'b0;  r_trap <= 1'b0;  r_cc <= 1'b0;  r_is_div <= 1'b0;
            r_neg_q <= 1'b0;  r_neg_r <= 1'b0;  r_ovf <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_trap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A mul/div start owns Y, so a coincident WRY is dropped.
                    if (y_we && !(start && (w_is_mul || w_is_div))) r_y <= y_in;
                    if (w_accept) begin
                        if (!(w_is_alu || w_is_shift || w_is_mul || w_is_div) || w_div0) begin
                            r_done <= 1'b1;
                            r_trap <= 1'b1;
                        end else if (w_is_alu || w_is_shift) begin
                            r_res  <= w_alu_res;
                            r_done <= 1'b1;
                            if (w_cc) begin
                                r_n <= w_alu_res[WIDTH-1];
                                r_z <= (w_alu_res == '0);
                                r_v <= w_alu_v;
                                r_c <= w_alu_c;
                            end
                        end else begin
                            r_hi     <= '0;
                            r_lo     <= w_a_mag;
                            r_opb    <= w_b_mag;
                            r_cnt    <= '0;
                            r_cc     <= w_cc;
                            r_is_div <= w_is_div;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_ovf    <= w_ovf;
                        end
                    end
                end
                S_MUL: begin
                    {r_hi, r_lo} <= {w_madd, r_lo[WIDTH-1:1]};
                    r_cnt        <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_hi  <= w_trial[WIDTH] ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : w_trial[WIDTH-1:0];
                    r_lo  <= {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_res  <= w_fix_res;
                    r_y    <= w_fix_y;
                    r_done <= 1'b1;
                    if (r_cc) begin
                        r_n <= w_fix_res[WIDTH-1];
                        r_z <= (w_fix_res == '0);
                        r_v <= r_is_div & r_ovf;
                        r_c <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res   = r_res;
    assign y_out = r_y;
    assign n     = r_n;
    assign z     = r_z;
    assign v     = r_v;
    assign c     = r_c;
    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign trap  = r_trap;

endmodule

// File: tb/tb_seq_alu_muldiv.sv
// Bench for seq_alu_muldiv: arithmetic reference model with a per-cycle compare,
// directed vectors with literal expectations, reset-in-flight and busy-ignore cases.
module tb_seq_alu_muldiv;
  localparam int W = 32;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, cin = 1'b0, y_we = 1'b0;
  logic [5:0] op = '0;
  logic [W-1:0] a = '0, b = '0, y_in = '0;
  logic [W-1:0] res, y_out;
  logic n, z, v, c, busy, done, trap;

  int checks = 0, errors = 0, prints = 0;

  seq_alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .y_we(y_we), .y_in(y_in), .res(res), .y_out(y_out), .n(n), .z(z), .v(v), .c(c),
    .busy(busy), .done(done), .trap(trap)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: kind 0 = single cycle, 1 = multi cycle, 2 = trap
  typedef struct packed {
    logic [1:0]   kind;
    logic [W-1:0] res;
    logic [W-1:0] y;
    logic [3:0]   f;
    logic         cc;
  } ref_t;

  function automatic ref_t ref_op(input logic [5:0] o, input logic [W-1:0] x, yv, input logic ci);
    ref_t r;
    logic [W:0] t;
    logic [2*W-1:0] p;
    longint sx, sy;
    logic ce;
    r = '0;
    r.cc = (o < 6'd32) && o[4];
    ce = ci & o[3];
    sx = $signed(x);
    sy = $signed(yv);
    if (o >= 6'd32) begin
      case (o)
        6'd37: r.res = x << yv[4:0];
        6'd38: r.res = x >> yv[4:0];
        6'd39: r.res = $unsigned($signed(x) >>> yv[4:0]);
        default: r.kind = 2'd2;
      endcase
    end else begin
      case (o[3:0])
        4'd0, 4'd8: begin
          t = {1'b0, x} + {1'b0, yv} + {{W{1'b0}}, ce};
          r.res = t[W-1:0];
          r.f[0] = t[W];
          r.f[1] = (x[W-1] == yv[W-1]) && (r.res[W-1] != x[W-1]);
        end
        4'd4, 4'd12: begin
          t = {1'b0, x} - {1'b0, yv} - {{W{1'b0}}, ce};
          r.res = t[W-1:0];
          r.f[0] = t[W];
          r.f[1] = (x[W-1] != yv[W-1]) && (r.res[W-1] != x[W-1]);
        end
        4'd1: r.res = x & yv;
        4'd2: r.res = x | yv;
        4'd3: r.res = x ^ yv;
        4'd5: r.res = x & ~yv;
        4'd6: r.res = x | ~yv;
        4'd7: r.res = ~(x ^ yv);
        4'd10: begin
          p = {{W{1'b0}}, x} * {{W{1'b0}}, yv};
          r.res = p[W-1:0]; r.y = p[2*W-1:W]; r.kind = 2'd1;
        end
        4'd11: begin
          p = sx * sy;
          r.res = p[W-1:0]; r.y = p[2*W-1:W]; r.kind = 2'd1;
        end
        4'd14: begin
          if (yv == '0) r.kind = 2'd2;
          else begin r.res = x / yv; r.y = x % yv; r.kind = 2'd1; end
        end
        4'd15: begin
          if (yv == '0) r.kind = 2'd2;
          else if (x == 32'h8000_0000 && yv == 32'hFFFF_FFFF) begin
            r.res = x; r.y = '0; r.f[1] = 1'b1; r.kind = 2'd1;
          end else begin
            r.res = W'(sx / sy); r.y = W'(sx % sy); r.kind = 2'd1;
          end
        end
        default: r.kind = 2'd2;
      endcase
    end
    r.f[3] = r.res[W-1];
    r.f[2] = (r.res == '0);
    return r;
  endfunction

  function automatic logic is_md(input logic [5:0] o);
    return (o < 6'd32) && ((o[3:0] == 4'd10) || (o[3:0] == 4'd11) || (o[3:0] == 4'd14) || (o[3:0] == 4'd15));
  endfunction

  logic [W-1:0] e_res = '0, e_y = '0;
  logic [3:0] e_f = '0;
  logic e_busy = 1'b0, e_done = 1'b0, e_trap = 1'b0;
  int m_cnt = 0;
  ref_t m_r, p_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_res = '0; e_y = '0; e_f = '0; e_busy = 1'b0; e_done = 1'b0; e_trap = 1'b0; m_cnt = 0;
    end else begin
      e_done = 1'b0;
      e_trap = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          e_busy = 1'b0; e_done = 1'b1; e_res = p_r.res; e_y = p_r.y;
          if (p_r.cc) e_f = p_r.f;
        end
      end else begin
        m_r = ref_op(op, a, b, cin);
        if (y_we && !(start && is_md(op))) e_y = y_in;
        if (start) begin
          case (m_r.kind)
            2'd2: begin e_done = 1'b1; e_trap = 1'b1; end
            2'd1: begin p_r = m_r; m_cnt = W + 1; e_busy = 1'b1; end
            default: begin
              e_res = m_r.res; e_done = 1'b1;
              if (m_r.cc) e_f = m_r.f;
            end
          endcase
        end
      end
    end
  end

  // scoreboard: every cycle, all outputs against the model
  always @(negedge clk) begin
    checks++;
    if ({res, y_out, n, z, v, c, busy, done, trap} !== {e_res, e_y, e_f, e_busy, e_done, e_trap}) begin
      errors++;
      if (prints < 20)
        $display("FAIL cycle_cmp t=%0t act res=%h y=%h nzvc=%b bdt=%b%b%b exp res=%h y=%h nzvc=%b bdt=%b%b%b",
                 $time, res, y_out, {n, z, v, c}, busy, done, trap, e_res, e_y, e_f, e_busy, e_done, e_trap);
      prints++;
    end
  end

  // driver tasks
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic write_y(input logic [W-1:0] val);
    @(negedge clk);
    y_we = 1'b1; y_in = val;
    @(negedge clk);
    y_we = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic ci, input int inj_at, output int lat, output int bsy, output logic tr);
    @(negedge clk);
    op = o; a = aa; b = bb; cin = ci; start = 1'b1;
    lat = 0; bsy = 0; tr = 1'b0;
    do begin
      @(negedge clk);
      start = 1'b0; y_we = 1'b0;
      lat++;
      if (busy) bsy++;
      if (lat == inj_at) begin
        start = 1'b1; op = 6'd16; a = 32'd1; b = 32'd1; y_we = 1'b1; y_in = 32'h0000_DEAD;
      end
    end while (!done && lat < 100);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout op=%0d act=no_done exp=done", o);
    end
    tr = trap;
  endtask

  int lat, bsy;
  logic tr;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res", res, 32'h0);
    chk("rst_y", y_out, 32'h0);
    chk("rst_flags", {28'h0, n, z, v, c}, 32'h0);
    chk("rst_bdt", {29'h0, busy, done, trap}, 32'h0);
    reset = 1'b0;

    run_op(6'd16, 32'h7FFF_FFFF, 32'h1, 1'b0, 0, lat, bsy, tr);
    chk("addcc_res", res, 32'h8000_0000);
    chk("addcc_nzvc", {28'h0, n, z, v, c}, 32'hA);
    chk("addcc_lat", 32'(lat), 32'd1);
    chk("addcc_busy", 32'(bsy), 32'd0);

    run_op(6'd26, 32'hFFFF_FFFF, 32'h2, 1'b0, 0, lat, bsy, tr);
    chk("umulcc_res", res, 32'hFFFF_FFFE);
    chk("umulcc_y", y_out, 32'h1);
    chk("umulcc_nzvc", {28'h0, n, z, v, c}, 32'h8);
    chk("umulcc_lat", 32'(lat), 32'd34);
    chk("umulcc_busy", 32'(bsy), 32'd33);

    run_op(6'd15, 32'hFFFF_FFF9, 32'h2, 1'b0, 0, lat, bsy, tr);
    chk("sdiv_res", res, 32'hFFFF_FFFD);
    chk("sdiv_y", y_out, 32'hFFFF_FFFF);
    chk("sdiv_nzvc", {28'h0, n, z, v, c}, 32'h8);

    run_op(6'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, lat, bsy, tr);
    chk("sdivcc_ovf_res", res, 32'h8000_0000);
    chk("sdivcc_ovf_y", y_out, 32'h0);
    chk("sdivcc_ovf_nzvc", {28'h0, n, z, v, c}, 32'hA);

    write_y(32'h55);
    chk("wry_y", y_out, 32'h55);
    run_op(6'd2, 32'h1234, 32'h0, 1'b0, 0, lat, bsy, tr);
    run_op(6'd30, 32'h77, 32'h0, 1'b0, 0, lat, bsy, tr);
    chk("div0_trap", {31'h0, tr}, 32'h1);
    chk("div0_lat", 32'(lat), 32'd1);
    chk("div0_res", res, 32'h1234);
    chk("div0_y", y_out, 32'h55);
    chk("div0_nzvc", {28'h0, n, z, v, c}, 32'hA);

    run_op(6'd11, 32'hFFFF_FFFD, 32'h7, 1'b0, 5, lat, bsy, tr);
    chk("smul_inj_res", res, 32'hFFFF_FFEB);
    chk("smul_inj_y", y_out, 32'hFFFF_FFFF);
    chk("smul_inj_nzvc", {28'h0, n, z, v, c}, 32'hA);
    chk("smul_inj_lat", 32'(lat), 32'd34);

    @(negedge clk);
    op = 6'd27; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", {31'h0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_res", res, 32'h0);
    chk("midrst_y", y_out, 32'h0);
    chk("midrst_bd", {30'h0, busy, done}, 32'h0);
    chk("midrst_nzvc", {28'h0, n, z, v, c}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op(6'd16, 32'h7FFF_FFFF, 32'h1, 1'b0, 0, lat, bsy, tr);
    run_op(6'd39, 32'h8000_0000, 32'h24, 1'b0, 0, lat, bsy, tr);
    chk("sra_res", res, 32'hF800_0000);
    chk("sra_nzvc", {28'h0, n, z, v, c}, 32'hA);
    run_op(6'd37, 32'h1, 32'd31, 1'b0, 0, lat, bsy, tr);
    chk("sll_res", res, 32'h8000_0000);
    chk("sll_nzvc", {28'h0, n, z, v, c}, 32'hA);

    run_op(6'd20, 32'h1, 32'h2, 1'b0, 0, lat, bsy, tr);
    chk("subcc_res", res, 32'hFFFF_FFFF);
    chk("subcc_nzvc", {28'h0, n, z, v, c}, 32'h9);
    run_op(6'd8, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, lat, bsy, tr);
    chk("addx_res", res, 32'h0);
    chk("addx_nzvc", {28'h0, n, z, v, c}, 32'h9);
    run_op(6'd24, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, lat, bsy, tr);
    chk("addxcc_nzvc", {28'h0, n, z, v, c}, 32'h5);
    run_op(6'd17, 32'hF0, 32'h0F, 1'b0, 0, lat, bsy, tr);
    chk("andcc_nzvc", {28'h0, n, z, v, c}, 32'h4);
    run_op(6'd27, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat, bsy, tr);
    chk("smulcc_res", res, 32'h1);
    chk("smulcc_y", y_out, 32'h0);
    chk("smulcc_nzvc", {28'h0, n, z, v, c}, 32'h0);
    run_op(6'd30, 32'd100, 32'd7, 1'b0, 0, lat, bsy, tr);
    chk("udivcc_res", res, 32'd14);
    chk("udivcc_y", y_out, 32'd2);
    run_op(6'd9, 32'h1, 32'h1, 1'b0, 0, lat, bsy, tr);
    chk("illegal_trap", {31'h0, tr}, 32'h1);
    chk("illegal_res", res, 32'd14);
    run_op(6'd28, 32'd5, 32'd3, 1'b1, 0, lat, bsy, tr);
    chk("subxcc_res", res, 32'd1);
    chk("subxcc_nzvc", {28'h0, n, z, v, c}, 32'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
